ps2_keyboard_tx: RTL and testbench

- Device-side PS/2 keyboard emulator. Serialises queued scan-code bytes onto ps2_clk/ps2_data as standard 11-bit device-to-host frames.
- Drives the existing PS/2 receiver in simulation and on NVBoard for self-test and replay of scan-code sequences.
- Sits between a scan-code producer (valid/ready byte stream) and the PS/2 lines. Contains a small FIFO and a frame FSM.

---
 rtl/ps2_keyboard_tx.sv | 124 ++++++++++++
 tb/tb_ps2_keyboard_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_tx.sv
// ps2_keyboard_tx: device-side PS/2 keyboard emulator serialising FIFO-queued scan codes into 11-bit frames
module ps2_keyboard_tx #(
  parameter int CLK_HALF   = 50,
  parameter int GAP        = 200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       host_inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       frame_done,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2((CLK_HALF > GAP ? CLK_HALF : GAP) + 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP - 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic overflow_q, overflow_d, avail_q, avail_d;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [10:0] frame_q, frame_d;
  logic ps2_clk_q, ps2_clk_d, ps2_data_q, ps2_data_d, frame_done_q, frame_done_d;
  logic push, pop, half_end, abort;
  logic [7:0] head;

  assign in_ready   = count_q != FULL;
  assign head       = mem_q[rd_ptr_q];
  assign ps2_clk    = ps2_clk_q;
  assign ps2_data   = ps2_data_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != S_IDLE) | (count_q != '0);

  always_comb begin
    push       = in_valid & in_ready;
    half_end   = cnt_q == HALF_END;
    abort      = host_inhibit & (idx_q != 4'd10);
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    pop        = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: if (avail_q && !host_inhibit) begin
        frame_d = {1'b1, ~^head, head, 1'b0};
        idx_d   = 4'd0;
        cnt_d   = '0;
        state_d = S_HIGH;
      end
      S_HIGH: begin
        cnt_d   = abort || half_end ? '0 : cnt_q + 1'b1;
        idx_d   = abort ? 4'd0 : idx_q;
        state_d = abort ? S_IDLE : half_end ? S_LOW : S_HIGH;
      end
      S_LOW: begin
        pop          = !abort && half_end && idx_q == 4'd10;
        frame_done_d = pop;
        cnt_d        = abort || half_end ? '0 : cnt_q + 1'b1;
        idx_d        = abort ? 4'd0 : half_end && !pop ? idx_q + 4'd1 : idx_q;
        state_d      = abort ? S_IDLE : pop ? S_GAP : half_end ? S_HIGH : S_LOW;
      end
      default: begin
        cnt_d   = cnt_q == GAP_END ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == GAP_END ? S_IDLE : S_GAP;
      end
    endcase
    ps2_clk_d  = state_d != S_LOW;
    ps2_data_d = (state_d == S_HIGH || state_d == S_LOW) ? frame_d[idx_d] : 1'b1;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    overflow_d = overflow_q | (in_valid & ~in_ready);
    avail_d    = count_q != '0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      avail_q      <= 1'b0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_q      <= '1;
      ps2_clk_q    <= 1'b1;
      ps2_data_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      avail_q      <= avail_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      ps2_clk_q    <= ps2_clk_d;
      ps2_data_q   <= ps2_data_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// tb_ps2_keyboard_tx: self-checking bench with PS/2 receiver model, byte scoreboard and frame vector table
module tb_ps2_keyboard_tx;
  localparam int CH = 4;
  localparam int GP = 8;
  localparam int FD = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic host_inhibit = 1'b0;
  logic in_ready, ps2_clk, ps2_data, busy, frame_done, overflow;
  int tests = 0;
  int fails = 0;
  typedef struct { logic [7:0] d; logic par; } vec_t;
  vec_t vecs [6];
  logic [7:0] exp_q [$];
  logic [10:0] cap_q [$];
  int falls = 0;
  int dones = 0;
  int nb = 0;
  int hi = 0;
  logic prev_clk = 1'b1;
  logic [10:0] raw = '0;

  ps2_keyboard_tx #(.CLK_HALF(CH), .GAP(GP), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .host_inhibit(host_inhibit), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    in_data = b;
    in_valid = 1'b1;
    if (in_ready) exp_q.push_back(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      nb = 0;
      hi = 0;
    end else begin
      if (prev_clk && !ps2_clk) begin
        raw = {ps2_data, raw[10:1]};
        nb++;
        falls++;
        if (nb == 11) begin
          nb = 0;
          cap_q.push_back(raw);
          check("start_bit", 32'(raw[0]), 32'd0);
          check("stop_bit", 32'(raw[10]), 32'd1);
          check("odd_parity", 32'(raw[9]), 32'(~^raw[8:1]));
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got 0x%0h, expected no frame", raw[8:1]);
          end else check("scoreboard_byte", 32'(raw[8:1]), 32'(exp_q.pop_front()));
        end
      end
      hi = ps2_clk ? hi + 1 : 0;
      if (hi > 2 * CH + 2) nb = 0;
      if (frame_done) dones++;
    end
    prev_clk = ps2_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, f0;
    logic [10:0] c;
    vecs[0] = '{8'h1C, 1'b0};
    vecs[1] = '{8'h00, 1'b1};
    vecs[2] = '{8'hF0, 1'b1};
    vecs[3] = '{8'h5A, 1'b1};
    vecs[4] = '{8'hFF, 1'b1};
    vecs[5] = '{8'h80, 1'b0};
    repeat (3) @(negedge clk);
    check("rst_ps2_clk", 32'(ps2_clk), 32'd1);
    check("rst_ps2_data", 32'(ps2_data), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    cap_q.delete();
    push(8'h1C);
    n = 0;
    while (ps2_data !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("start_latency", 32'(n), 32'd2);
    while (ps2_clk !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("first_fall", 32'(n), 32'(2 + CH));
    while (frame_done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    check("frame_done_time", 32'(n), 32'(2 + 22 * CH));
    while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    check("busy_low_time", 32'(n), 32'(2 + 22 * CH + GP));
    c = cap_q.size() > 0 ? cap_q.pop_front() : 'x;
    check("frame_1c_bits", 32'(c), 32'(11'b10000111000));

    for (int i = 0; i < 6; i++) begin
      cap_q.delete();
      push(vecs[i].d);
      n = 0;
      while (frame_done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      check("vec_done_time", 32'(n), 32'(2 + 22 * CH));
      while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
      c = cap_q.size() > 0 ? cap_q.pop_front() : 'x;
      check("vec_data", 32'(c[8:1]), 32'(vecs[i].d));
      check("vec_parity", 32'(c[9]), 32'(vecs[i].par));
    end

    cap_q.delete();
    push(8'h00);
    push(8'hF0);
    n = 0;
    while (frame_done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    n = 0;
    while (ps2_data !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("b2b_start_gap", 32'(n), 32'(GP + 1));
    n = 0;
    while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    check("b2b_frames", 32'(cap_q.size()), 32'd2);
    c = cap_q.size() > 0 ? cap_q.pop_front() : 'x;
    check("b2b_par0", 32'(c[9]), 32'd1);
    c = cap_q.size() > 0 ? cap_q.pop_front() : 'x;
    check("b2b_par1", 32'(c[9]), 32'd1);
    check("b2b_data1", 32'(c[8:1]), 32'hF0);

    check("pre_overflow", 32'(overflow), 32'd0);
    host_inhibit = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check("in_ready_full", 32'(in_ready), 32'd0);
      push(8'(8'h10 + i));
    end
    check("overflow_set", 32'(overflow), 32'd1);
    d0 = dones;
    repeat (20) @(negedge clk);
    check("inhibit_blocks", 32'(ps2_clk & ps2_data), 32'd1);
    check("inhibit_busy", 32'(busy), 32'd1);
    host_inhibit = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    check("ovf_frame_count", 32'(dones - d0), 32'd8);
    check("ovf_sb_empty", 32'(exp_q.size()), 32'd0);
    check("overflow_sticky", 32'(overflow), 32'd1);

    cap_q.delete();
    d0 = dones;
    f0 = falls;
    push(8'h5A);
    n = 0;
    while (falls - f0 < 5 && n < 200) begin @(negedge clk); n++; end
    host_inhibit = 1'b1;
    @(negedge clk);
    check("abort_clk_high", 32'(ps2_clk), 32'd1);
    check("abort_data_high", 32'(ps2_data), 32'd1);
    repeat (19) @(negedge clk);
    check("abort_no_done", 32'(dones - d0), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    host_inhibit = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    check("resend_done_count", 32'(dones - d0), 32'd1);
    c = cap_q.size() > 0 ? cap_q.pop_front() : 'x;
    check("resend_data", 32'(c), 32'({1'b1, 1'b1, 8'h5A, 1'b0}));

    d0 = dones;
    f0 = falls;
    push(8'h33);
    n = 0;
    while (falls - f0 < 11 && n < 200) begin @(negedge clk); n++; end
    host_inhibit = 1'b1;
    n = 0;
    while (frame_done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("stopbit_done", 32'(frame_done), 32'd1);
    n = 0;
    while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("stopbit_popped", 32'(busy), 32'd0);
    repeat (30) @(negedge clk);
    host_inhibit = 1'b0;
    repeat (150) @(negedge clk);
    check("stopbit_no_resend", 32'(falls - f0), 32'd11);
    check("stopbit_one_done", 32'(dones - d0), 32'd1);

    f0 = falls;
    push(8'h77);
    n = 0;
    while (falls - f0 < 5 && n < 200) begin @(negedge clk); n++; end
    #2 reset = 1'b1;
    #1;
    check("areset_clk", 32'(ps2_clk), 32'd1);
    check("areset_data", 32'(ps2_data), 32'd1);
    check("areset_overflow", 32'(overflow), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    d0 = dones;
    f0 = falls;
    repeat (300) @(negedge clk);
    check("post_reset_quiet", 32'(falls - f0), 32'd0);
    check("post_reset_no_done", 32'(dones - d0), 32'd0);
    check("post_reset_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
